// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction port of a
// 1-cycle-latency memory and hands {instr, pc} to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 imem_en,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_data,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [31:0]          out_pc,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  logic [31:0]          pc_q;
  logic [31:0]          out_pc_q;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 advance;
  logic                 transfer;

  // A redirect wins over a stall; the presented word is squashed in that cycle.
  always_comb begin
    advance     = ~reset & (redirect_valid | ~valid_q | out_ready);
    imem_en     = advance;
    imem_addr   = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
    out_valid   = valid_q & ~redirect_valid;
    transfer    = out_valid & out_ready;
    out_instr   = imem_data;
    out_pc      = out_pc_q;
    fetch_count = cnt_q;
  end

  // When stalled everything holds, and imem_en=0 keeps imem_data stable too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= {RESET_ADDR[31:2], 2'b00};
      out_pc_q <= 32'h0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (advance) begin
        out_pc_q <= imem_addr;
        pc_q     <= imem_addr + 32'd4;
        valid_q  <= 1'b1;
      end
      if (transfer) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus a transfer
// scoreboard fed from the table, and a hand-written async-reset sequence.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        ready;
    logic        exp_en;
    logic [31:0] exp_addr;
    logic        exp_ov;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[20];
  logic [31:0] sb_pc_q[$];
  logic [31:0] sb_instr_q[$];
  int          exp_count;

  fetch_unit #(.RESET_ADDR(32'h0000_0000), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word at byte address a is (a<<5)+0x13, so 0->0x13, 4->0x93, ...
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a << 5) + 32'h13;
  endfunction

  always_ff @(posedge clk) begin
    if (imem_en) imem_data <= rom_word(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic ready,
                              input logic en, input logic [31:0] addr,
                              input logic ov, input logic [31:0] opc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.ready = ready; v.exp_en = en;
    v.exp_addr = addr; v.exp_ov = ov; v.exp_pc = opc;
    return v;
  endfunction

  // Called at posedge+1: drive, check combinational outputs, advance one cycle.
  task automatic applyStimulus(input vec_t v, input int idx);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    out_ready      = v.ready;
    if (v.exp_ov && v.ready) begin
      sb_pc_q.push_back(v.exp_pc);
      sb_instr_q.push_back(rom_word(v.exp_pc));
    end
    #1;
    checkOutput($sformatf("imem_en[%0d]", idx), {31'h0, imem_en}, {31'h0, v.exp_en});
    if (v.exp_en) checkOutput($sformatf("imem_addr[%0d]", idx), imem_addr, v.exp_addr);
    checkOutput($sformatf("out_valid[%0d]", idx), {31'h0, out_valid}, {31'h0, v.exp_ov});
    if (v.exp_ov) begin
      checkOutput($sformatf("out_pc[%0d]", idx), out_pc, v.exp_pc);
      checkOutput($sformatf("out_instr[%0d]", idx), out_instr, rom_word(v.exp_pc));
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transfer must match the next expected {pc, instr}.
  always @(negedge clk) begin
    if (reset) begin
      exp_count = 0;
    end else begin
      checkOutput("fetch_count", fetch_count, exp_count);
      if (out_valid && out_ready) begin
        if (sb_pc_q.size() == 0) begin
          checkOutput("unexpected_transfer_pc", out_pc, 32'hDEAD_BEEF);
        end else begin
          checkOutput("sb_pc", out_pc, sb_pc_q.pop_front());
          checkOutput("sb_instr", out_instr, sb_instr_q.pop_front());
        end
        exp_count++;
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_count = 0;
    //                rv  rpc            rdy  en  addr           ov  out_pc
    vecs[0]  = mk(0, 32'h0,          1, 1, 32'h0000_0000, 0, 32'h0);
    vecs[1]  = mk(0, 32'h0,          1, 1, 32'h0000_0004, 1, 32'h0000_0000);
    vecs[2]  = mk(0, 32'h0,          1, 1, 32'h0000_0008, 1, 32'h0000_0004);
    vecs[3]  = mk(0, 32'h0,          1, 1, 32'h0000_000C, 1, 32'h0000_0008);
    vecs[4]  = mk(0, 32'h0,          0, 0, 32'h0000_0010, 1, 32'h0000_000C);
    vecs[5]  = mk(0, 32'h0,          0, 0, 32'h0000_0010, 1, 32'h0000_000C);
    vecs[6]  = mk(0, 32'h0,          0, 0, 32'h0000_0010, 1, 32'h0000_000C);
    vecs[7]  = mk(0, 32'h0,          1, 1, 32'h0000_0010, 1, 32'h0000_000C);
    vecs[8]  = mk(1, 32'h0000_0103,  1, 1, 32'h0000_0100, 0, 32'h0000_0010);
    vecs[9]  = mk(0, 32'h0,          1, 1, 32'h0000_0104, 1, 32'h0000_0100);
    vecs[10] = mk(0, 32'h0,          1, 1, 32'h0000_0108, 1, 32'h0000_0104);
    vecs[11] = mk(0, 32'h0,          0, 0, 32'h0000_010C, 1, 32'h0000_0108);
    vecs[12] = mk(1, 32'h0000_0040,  0, 1, 32'h0000_0040, 0, 32'h0000_0108);
    vecs[13] = mk(0, 32'h0,          0, 0, 32'h0000_0044, 1, 32'h0000_0040);
    vecs[14] = mk(1, 32'h0000_0040,  0, 1, 32'h0000_0040, 0, 32'h0000_0040);
    vecs[15] = mk(1, 32'h0000_0080,  0, 1, 32'h0000_0080, 0, 32'h0000_0040);
    vecs[16] = mk(0, 32'h0,          1, 1, 32'h0000_0084, 1, 32'h0000_0080);
    vecs[17] = mk(1, 32'hFFFF_FFFC,  1, 1, 32'hFFFF_FFFC, 0, 32'h0000_0084);
    vecs[18] = mk(0, 32'h0,          1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    vecs[19] = mk(0, 32'h0,          1, 1, 32'h0000_0004, 1, 32'h0000_0000);

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_imem_en", {31'h0, imem_en}, 32'h0);
    checkOutput("reset_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_fetch_count", fetch_count, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

    // Async reset mid-cycle: outputs must clear with no clock edge.
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    checkOutput("pre_reset_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("pre_reset_out_pc", out_pc, 32'h0000_0004);
    checkOutput("pre_reset_count", fetch_count, 32'd9);
    reset = 1'b1;
    #1;
    checkOutput("async_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async_imem_en", {31'h0, imem_en}, 32'h0);
    checkOutput("async_fetch_count", fetch_count, 32'h0);
    checkOutput("async_out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(mk(0, 32'h0, 1, 1, 32'h0000_0000, 0, 32'h0), 100);
    applyStimulus(mk(0, 32'h0, 1, 1, 32'h0000_0004, 1, 32'h0000_0000), 101);
    applyStimulus(mk(0, 32'h0, 0, 0, 32'h0000_0008, 1, 32'h0000_0004), 102);
    @(posedge clk);
    #1;

    checkOutput("sb_leftover", sb_pc_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
